// File: rtl/jtag_tap_slave_if.sv
// JTAG TAP slave link bundle.
// Carries the pin-level JTAG signals from the master (tck, tms, tdi, tdo) and the
// user-logic side of the TAP (tap_state, ir, ir_update, capture_data, update_data,
// update_valid).
//   master : drives tck/tms/tdi/capture_data, observes everything else
//   slave  : the TAP controller end
interface jtag_tap_slave_if #(
  parameter int unsigned IR_WIDTH = 10,
  parameter int unsigned DR_WIDTH = 8
);
  logic                tck;
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic [3:0]          tap_state;
  logic [IR_WIDTH-1:0] ir;
  logic                ir_update;
  logic [DR_WIDTH-1:0] capture_data;
  logic [DR_WIDTH-1:0] update_data;
  logic                update_valid;

  modport master (
    output tck, tms, tdi, capture_data,
    input  tdo, tap_state, ir, ir_update, update_data, update_valid
  );

  modport slave (
    input  tck, tms, tdi, capture_data,
    output tdo, tap_state, ir, ir_update, update_data, update_valid
  );
endinterface

// File: rtl/jtag_tap_slave.sv
// Target-side IEEE 1149.1 TAP controller in the system clock domain.
// tck/tms/tdi are oversampled through 2-flop synchronizers; a third tck flop
// gives registered one-clk rise/fall strobes. The 16-state TAP machine and the
// IR/DR/bypass shifters advance on the rise strobe; tdo and the update outputs
// change on the fall strobe.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave modport of jtag_tap_slave_if (JTAG pins + user-logic side)
module jtag_tap_slave #(
  parameter int unsigned         IR_WIDTH   = 10,
  parameter int unsigned         DR_WIDTH   = 8,
  parameter logic [IR_WIDTH-1:0] INSTR_DATA = 10'h002
) (
  input logic             clk,
  input logic             rst,
  jtag_tap_slave_if.slave bus
);

  typedef enum logic [3:0] {
    StTlr   = 4'd0,
    StRti   = 4'd1,
    StSelDr = 4'd2,
    StCapDr = 4'd3,
    StShDr  = 4'd4,
    StEx1Dr = 4'd5,
    StPaDr  = 4'd6,
    StEx2Dr = 4'd7,
    StUpdDr = 4'd8,
    StSelIr = 4'd9,
    StCapIr = 4'd10,
    StShIr  = 4'd11,
    StEx1Ir = 4'd12,
    StPaIr  = 4'd13,
    StEx2Ir = 4'd14,
    StUpdIr = 4'd15
  } tap_state_e;

  // Synchronizers and edge strobes.
  logic tck_s1_q, tck_s2_q, tck_s3_q;
  logic tms_s1_q, tms_s2_q;
  logic tdi_s1_q, tdi_s2_q;
  logic rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_s1_q <= 1'b0;
      tck_s2_q <= 1'b0;
      tck_s3_q <= 1'b0;
      tms_s1_q <= 1'b0;
      tms_s2_q <= 1'b0;
      tdi_s1_q <= 1'b0;
      tdi_s2_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      tck_s1_q <= bus.tck;
      tck_s2_q <= tck_s1_q;
      tck_s3_q <= tck_s2_q;
      tms_s1_q <= bus.tms;
      tms_s2_q <= tms_s1_q;
      tdi_s1_q <= bus.tdi;
      tdi_s2_q <= tdi_s1_q;
      // Registered so the TAP acts 4 clk after the pin edge.
      rise_q   <= tck_s2_q & ~tck_s3_q;
      fall_q   <= ~tck_s2_q & tck_s3_q;
    end
  end

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [DR_WIDTH-1:0] dr_shift_q;
  logic [DR_WIDTH-1:0] update_data_q;
  logic                bypass_q;
  logic                tdo_q;
  logic                ir_update_q;
  logic                update_valid_q;
  logic                dr_sel;

  assign dr_sel = (ir_q == INSTR_DATA);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = tms_s2_q ? StTlr   : StRti;
      StRti:   state_d = tms_s2_q ? StSelDr : StRti;
      StSelDr: state_d = tms_s2_q ? StSelIr : StCapDr;
      StCapDr: state_d = tms_s2_q ? StEx1Dr : StShDr;
      StShDr:  state_d = tms_s2_q ? StEx1Dr : StShDr;
      StEx1Dr: state_d = tms_s2_q ? StUpdDr : StPaDr;
      StPaDr:  state_d = tms_s2_q ? StEx2Dr : StPaDr;
      StEx2Dr: state_d = tms_s2_q ? StUpdDr : StShDr;
      StUpdDr: state_d = tms_s2_q ? StSelDr : StRti;
      StSelIr: state_d = tms_s2_q ? StTlr   : StCapIr;
      StCapIr: state_d = tms_s2_q ? StEx1Ir : StShIr;
      StShIr:  state_d = tms_s2_q ? StEx1Ir : StShIr;
      StEx1Ir: state_d = tms_s2_q ? StUpdIr : StPaIr;
      StPaIr:  state_d = tms_s2_q ? StEx2Ir : StPaIr;
      StEx2Ir: state_d = tms_s2_q ? StUpdIr : StShIr;
      StUpdIr: state_d = tms_s2_q ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StTlr;
      ir_shift_q     <= '0;
      ir_q           <= '1;
      dr_shift_q     <= '0;
      update_data_q  <= '0;
      bypass_q       <= 1'b0;
      tdo_q          <= 1'b0;
      ir_update_q    <= 1'b0;
      update_valid_q <= 1'b0;
    end else begin
      ir_update_q    <= 1'b0;
      update_valid_q <= 1'b0;
      if (rise_q) begin
        // Actions are keyed on the state being left.
        case (state_q)
          StCapIr: ir_shift_q <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
          StCapDr: begin
            if (dr_sel) dr_shift_q <= bus.capture_data;
            else        bypass_q   <= 1'b0;
          end
          StShIr:  ir_shift_q <= {tdi_s2_q, ir_shift_q[IR_WIDTH-1:1]};
          StShDr: begin
            if (dr_sel) dr_shift_q <= {tdi_s2_q, dr_shift_q[DR_WIDTH-1:1]};
            else        bypass_q   <= tdi_s2_q;
          end
          default: ;
        endcase
        state_q <= state_d;
      end else if (fall_q) begin
        tdo_q <= 1'b0;
        case (state_q)
          StUpdIr: begin
            ir_q        <= ir_shift_q;
            ir_update_q <= 1'b1;
          end
          StUpdDr: begin
            if (dr_sel) begin
              update_data_q  <= dr_shift_q;
              update_valid_q <= 1'b1;
            end
          end
          StShIr:  tdo_q <= ir_shift_q[0];
          StShDr:  tdo_q <= dr_sel ? dr_shift_q[0] : bypass_q;
          default: ;
        endcase
      end
      // Test-Logic-Reset holds BYPASS silently.
      if (state_q == StTlr) ir_q <= '1;
    end
  end

  assign bus.tdo          = tdo_q;
  assign bus.tap_state    = state_q;
  assign bus.ir           = ir_q;
  assign bus.ir_update    = ir_update_q;
  assign bus.update_data  = update_data_q;
  assign bus.update_valid = update_valid_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Self-checking bench for jtag_tap_slave: a pin-level TAP model advanced on each
// tck edge, compared against the DUT once each tck phase has settled, plus
// literal expectations for the directed scenarios.
module tb_jtag_tap_slave;
  localparam int          IW    = 10;
  localparam int          DW    = 8;
  localparam logic [9:0]  INSTR = 10'h002;

  // Next state indexed by state*2 + tms.
  localparam int NXT [32] = '{1, 0, 1, 2, 3, 9, 4, 5, 4, 5, 6, 8, 6, 7, 4, 8,
                              1, 2, 10, 0, 11, 12, 11, 12, 13, 15, 13, 14, 11, 15, 1, 2};
  // tms paths from TLR to each state, LSB first.
  localparam int PLEN  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  localparam int PBITS [16] = '{0, 0, 2, 2, 2, 10, 10, 42, 26, 6, 6, 6, 22, 22, 86, 54};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtag_tap_slave_if #(.IR_WIDTH(IW), .DR_WIDTH(DW)) bus ();

  jtag_tap_slave #(.IR_WIDTH(IW), .DR_WIDTH(DW), .INSTR_DATA(INSTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state.
  int         m_state;
  logic [9:0] m_ir, m_irsh;
  logic [7:0] m_dr, m_upd;
  logic       m_byp, m_tdo;
  int         exp_iu = 0, exp_uv = 0;
  int         act_iu = 0, act_uv = 0;

  event chk_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ir    = '1;
    m_irsh  = '0;
    m_dr    = '0;
    m_upd   = '0;
    m_byp   = 1'b0;
    m_tdo   = 1'b0;
  endtask

  task automatic m_rise(input logic t_ms, input logic t_di);
    case (m_state)
      10: m_irsh = 10'd1;
      3:  if (m_ir == INSTR) m_dr = bus.capture_data; else m_byp = 1'b0;
      11: m_irsh = (m_irsh >> 1) | (10'(t_di) << 9);
      4:  if (m_ir == INSTR) m_dr = (m_dr >> 1) | (8'(t_di) << 7); else m_byp = t_di;
      default: ;
    endcase
    m_state = NXT[m_state * 2 + int'(t_ms)];
    if (m_state == 0) m_ir = '1;
  endtask

  task automatic m_fall();
    m_tdo = 1'b0;
    case (m_state)
      15: begin m_ir = m_irsh; exp_iu++; end
      8:  if (m_ir == INSTR) begin m_upd = m_dr; exp_uv++; end
      11: m_tdo = m_irsh[0];
      4:  m_tdo = (m_ir == INSTR) ? m_dr[0] : m_byp;
      default: ;
    endcase
  endtask

  // Pulse monitor: counts high clk cycles, so a wide pulse shows up as extra counts.
  always @(negedge clk) begin
    if (bus.ir_update === 1'b1)    act_iu++;
    if (bus.update_valid === 1'b1) act_uv++;
  end

  // Compare process.
  always @(chk_ev) begin
    check("tap_state",    32'(bus.tap_state),   32'(m_state));
    check("ir",           32'(bus.ir),          32'(m_ir));
    check("tdo",          32'(bus.tdo),         32'(m_tdo));
    check("update_data",  32'(bus.update_data), 32'(m_upd));
    check("ir_update_n",  32'(act_iu),          32'(exp_iu));
    check("upd_valid_n",  32'(act_uv),          32'(exp_uv));
  end

  // One tck period; returns tdo as seen after the falling edge settles.
  task automatic cyc(input logic t_ms, input logic t_di, output logic tdo_s);
    @(negedge clk);
    bus.tms = t_ms;
    bus.tdi = t_di;
    repeat (2) @(negedge clk);
    bus.tck = 1'b1;
    m_rise(t_ms, t_di);
    repeat (5) @(negedge clk);
    -> chk_ev;
    @(negedge clk);
    bus.tck = 1'b0;
    m_fall();
    repeat (5) @(negedge clk);
    -> chk_ev;
    tdo_s = bus.tdo;
  endtask

  task automatic to_tlr();
    logic t;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, t);
  endtask

  task automatic load_ir(input logic [9:0] v, output logic b0, output logic b1);
    logic t;
    cyc(1'b1, 1'b0, t);
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    b0 = t;
    b1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'(i == 9), v[i], t);
      if (i == 0) b1 = t;
    end
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
  endtask

  task automatic dr_rw(input logic [7:0] d, output logic [7:0] rd);
    logic t;
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    rd[0] = t;
    for (int i = 0; i < 8; i++) begin
      cyc(1'(i == 7), d[i], t);
      if (i < 7) rd[i+1] = t;
    end
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
  endtask

  initial begin
    logic       t, b0, b1;
    logic [7:0] rd;
    logic [7:0] pd;

    rst = 1'b1;
    bus.tck = 1'b0;
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    bus.capture_data = 8'hA5;
    model_reset();
    repeat (3) @(negedge clk);
    -> chk_ev;
    check("rst_state", 32'(bus.tap_state),    32'd0);
    check("rst_ir",    32'(bus.ir),           32'h3FF);
    check("rst_tdo",   32'(bus.tdo),          32'd0);
    check("rst_upd",   32'(bus.update_data),  32'd0);
    check("rst_uv",    32'(bus.update_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // IR load.
    cyc(1'b0, 1'b0, t);
    load_ir(INSTR, b0, b1);
    check("ir_cap_bit0", 32'(b0), 32'd1);
    check("ir_cap_bit1", 32'(b1), 32'd0);
    check("ir_loaded",   32'(bus.ir), 32'h002);
    check("ir_pulses",   32'(act_iu), 32'd1);

    // DR read/write.
    dr_rw(8'h3C, rd);
    check("dr_tdo_seq",  32'(rd), 32'hA5);
    check("dr_update",   32'(bus.update_data), 32'h3C);
    check("dr_pulses",   32'(act_uv), 32'd1);

    // Bypass.
    to_tlr();
    check("tlr_ir", 32'(bus.ir), 32'h3FF);
    cyc(1'b0, 1'b0, t);
    dr_rw(8'hF0, rd);
    check("byp_tdo_seq", 32'(rd), 32'hE0);
    check("byp_no_upd",  32'(bus.update_data), 32'h3C);
    check("byp_pulses",  32'(act_uv), 32'd1);

    // Pause/resume.
    load_ir(INSTR, b0, b1);
    bus.capture_data = 8'h5A;
    pd = 8'hC3;
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    for (int i = 0; i < 4; i++) cyc(1'(i == 3), pd[i], t);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, t);
    check("pause_state", 32'(bus.tap_state), 32'd6);
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    for (int i = 4; i < 8; i++) cyc(1'(i == 7), pd[i], t);
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    check("pause_update", 32'(bus.update_data), 32'hC3);
    check("pause_pulses", 32'(act_uv), 32'd2);

    // Async reset mid-shift (capture A5, two shifts: tdo shows bit 2 = 1).
    bus.capture_data = 8'hA5;
    cyc(1'b1, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    cyc(1'b0, 1'b0, t);
    cyc(1'b0, 1'b1, t);
    cyc(1'b0, 1'b1, t);
    check("pre_rst_tdo", 32'(t), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(bus.tap_state),    32'd0);
    check("mid_rst_ir",    32'(bus.ir),           32'h3FF);
    check("mid_rst_tdo",   32'(bus.tdo),          32'd0);
    check("mid_rst_uv",    32'(bus.update_valid), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cyc(1'b0, 1'b0, t);
    check("post_rst_pulses", 32'(act_uv), 32'd2);

    // Reset from every state.
    for (int s = 0; s < 16; s++) begin
      to_tlr();
      for (int k = 0; k < PLEN[s]; k++) cyc(1'((PBITS[s] >> k) & 1), 1'b0, t);
      check("walk_state", 32'(bus.tap_state), 32'(s));
      to_tlr();
      check("five_tms_state", 32'(bus.tap_state), 32'd0);
      check("five_tms_ir",    32'(bus.ir),        32'h3FF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
